// File: rtl/ts_demuxer.sv
// ts_demuxer: splits the tagged muxed TS stream into four channels through a two-bank ping-pong buffer.
// Latency: first byte out 2 cycles after the last byte in; no backpressure, packets are dropped when both banks are full.
module ts_demuxer #(
  parameter int         PKT_LEN   = 188,
  parameter logic [5:0] TAG_BASE  = 6'b010001,
  parameter logic [7:0] SYNC_OUT  = 8'h47,
  parameter int         LOCK_GOOD = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  DATA_IN,
  input  logic        D_VALID_IN,
  input  logic        P_SYNC_IN,
  input  logic [3:0]  CH_ENABLE,
  output logic [7:0]  DATA_OUT,
  output logic [3:0]  D_VALID_OUT,
  output logic        P_SYNC_OUT,
  output logic        SYNC_LOCKED,
  output logic [15:0] ERR_COUNT
);

  localparam logic [7:0] LAST   = 8'(PKT_LEN - 1);
  localparam logic [7:0] LOCK_N = 8'(LOCK_GOOD);

  typedef enum logic [1:0] {W_HUNT, W_FILL, W_DROP} wr_state_t;
  typedef enum logic       {R_IDLE, R_READ}         rd_state_t;

  logic [7:0] mem [2][PKT_LEN];

  wr_state_t  w_state, w_state_nx;
  logic [7:0] w_cnt, w_cnt_nx;
  logic [1:0] w_ch, w_ch_nx;
  logic       wr_bank, wr_bank_nx;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [1:0] err_inc;
  logic       pkt_done;
  logic       tag_ok;

  rd_state_t  r_state, r_state_nx;
  logic [7:0] r_cnt, r_cnt_nx;
  logic [1:0] r_ch, r_ch_nx;
  logic       rd_bank, rd_bank_nx;
  logic       rd_free;
  logic       out_en;
  logic       out_first;

  logic [1:0] full, full_nx;
  logic [1:0] bank_ch [2];
  logic [7:0] good_cnt;
  logic [16:0] err_sum;

  assign tag_ok  = (DATA_IN[7:2] == TAG_BASE);
  assign err_sum = {1'b0, ERR_COUNT} + {15'd0, err_inc};

  always_comb begin
    w_state_nx = w_state;
    w_cnt_nx   = w_cnt;
    w_ch_nx    = w_ch;
    wr_bank_nx = wr_bank;
    mem_we     = 1'b0;
    mem_waddr  = w_cnt;
    err_inc    = 2'd0;
    pkt_done   = 1'b0;
    if (D_VALID_IN) begin
      if (w_state == W_FILL && !P_SYNC_IN) begin
        mem_we = 1'b1;
        if (w_cnt == LAST) begin
          pkt_done   = 1'b1;
          wr_bank_nx = ~wr_bank;
          w_state_nx = W_HUNT;
        end else begin
          w_cnt_nx = w_cnt + 8'd1;
        end
      end else if (P_SYNC_IN) begin
        // A sync inside FILL is a short packet; the same byte then starts a new hunt.
        if (w_state == W_FILL) err_inc = 2'd1;
        if (!tag_ok) begin
          err_inc    = err_inc + 2'd1;
          w_state_nx = W_HUNT;
        end else if (full[wr_bank]) begin
          err_inc    = err_inc + 2'd1;
          w_state_nx = W_DROP;
        end else begin
          mem_we     = 1'b1;
          mem_waddr  = 8'd0;
          w_ch_nx    = DATA_IN[1:0];
          w_cnt_nx   = 8'd1;
          w_state_nx = W_FILL;
        end
      end
    end
  end

  always_comb begin
    r_state_nx = r_state;
    r_cnt_nx   = r_cnt;
    r_ch_nx    = r_ch;
    rd_bank_nx = rd_bank;
    rd_free    = 1'b0;
    out_en     = 1'b0;
    out_first  = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (full[rd_bank]) begin
          if (CH_ENABLE[bank_ch[rd_bank]]) begin
            out_en     = 1'b1;
            out_first  = 1'b1;
            r_ch_nx    = bank_ch[rd_bank];
            r_cnt_nx   = 8'd1;
            r_state_nx = R_READ;
          end else begin
            rd_free    = 1'b1;
            rd_bank_nx = ~rd_bank;
          end
        end
      end
      R_READ: begin
        out_en = 1'b1;
        if (r_cnt == LAST) begin
          rd_free    = 1'b1;
          rd_bank_nx = ~rd_bank;
          r_state_nx = R_IDLE;
        end else begin
          r_cnt_nx = r_cnt + 8'd1;
        end
      end
      default: r_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    full_nx = full;
    if (rd_free)  full_nx[rd_bank] = 1'b0;
    if (pkt_done) full_nx[wr_bank] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem[wr_bank][mem_waddr] <= DATA_IN;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      w_state     <= W_HUNT;
      w_cnt       <= 8'd0;
      w_ch        <= 2'd0;
      wr_bank     <= 1'b0;
      r_state     <= R_IDLE;
      r_cnt       <= 8'd0;
      r_ch        <= 2'd0;
      rd_bank     <= 1'b0;
      full        <= 2'b00;
      bank_ch[0]  <= 2'd0;
      bank_ch[1]  <= 2'd0;
      good_cnt    <= 8'd0;
      DATA_OUT    <= 8'd0;
      D_VALID_OUT <= 4'd0;
      P_SYNC_OUT  <= 1'b0;
      SYNC_LOCKED <= 1'b0;
      ERR_COUNT   <= 16'd0;
    end else begin
      w_state <= w_state_nx;
      w_cnt   <= w_cnt_nx;
      w_ch    <= w_ch_nx;
      wr_bank <= wr_bank_nx;
      r_state <= r_state_nx;
      r_cnt   <= r_cnt_nx;
      r_ch    <= r_ch_nx;
      rd_bank <= rd_bank_nx;
      full    <= full_nx;
      if (pkt_done) bank_ch[wr_bank] <= w_ch;
      // Byte 0 never comes from the RAM: the tag is replaced by the fixed sync byte.
      DATA_OUT    <= !out_en ? 8'd0 : (out_first ? SYNC_OUT : mem[rd_bank][r_cnt]);
      D_VALID_OUT <= out_en ? (4'b0001 << r_ch_nx) : 4'b0000;
      P_SYNC_OUT  <= out_first;
      ERR_COUNT   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      if (err_inc != 2'd0) begin
        good_cnt    <= 8'd0;
        SYNC_LOCKED <= 1'b0;
      end else if (pkt_done) begin
        if (good_cnt != LOCK_N) good_cnt <= good_cnt + 8'd1;
        if (good_cnt + 8'd1 >= LOCK_N) SYNC_LOCKED <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ts_demuxer.sv
// Bench for ts_demuxer: scoreboard of expected output packets, filled as input packets are driven.
module tb_ts_demuxer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  DATA_IN;
  logic        D_VALID_IN;
  logic        P_SYNC_IN;
  logic [3:0]  CH_ENABLE;
  logic [7:0]  DATA_OUT;
  logic [3:0]  D_VALID_OUT;
  logic        P_SYNC_OUT;
  logic        SYNC_LOCKED;
  logic [15:0] ERR_COUNT;

  ts_demuxer dut (
    .CLK(CLK), .RST(RST), .DATA_IN(DATA_IN), .D_VALID_IN(D_VALID_IN),
    .P_SYNC_IN(P_SYNC_IN), .CH_ENABLE(CH_ENABLE), .DATA_OUT(DATA_OUT),
    .D_VALID_OUT(D_VALID_OUT), .P_SYNC_OUT(P_SYNC_OUT),
    .SYNC_LOCKED(SYNC_LOCKED), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int mon_idx = 0;
  int pkt_cnt = 0;
  int first_cyc = 0;
  int last_cyc = 0;
  bit seen_first = 0;
  logic [1:0] cur_ch;
  logic [1:0] exp_ch_q [$];
  logic [7:0] exp_b_q [$];

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
  endtask

  // Output monitor: once a packet starts, every following cycle must belong to it.
  always @(negedge CLK) begin
    if (!RST) begin
      mon_idx = 0;
      exp_ch_q.delete();
      exp_b_q.delete();
    end else if (mon_idx != 0 || D_VALID_OUT != 4'd0) begin
      if (mon_idx == 0 && exp_ch_q.size() == 0) begin
        chk("unexpected_vld", {28'd0, D_VALID_OUT}, 32'd0);
      end else begin
        if (mon_idx == 0) begin
          cur_ch = exp_ch_q.pop_front();
          if (!seen_first) begin
            seen_first = 1;
            first_cyc  = cyc;
          end
        end
        chk("vld", {28'd0, D_VALID_OUT}, 32'd1 << cur_ch);
        chk("psync", {31'd0, P_SYNC_OUT}, (mon_idx == 0) ? 32'd1 : 32'd0);
        if (exp_b_q.size() == 0) chk("missing_exp_byte", mon_idx, 32'hFFFF);
        else chk("dat", {24'd0, DATA_OUT}, {24'd0, exp_b_q.pop_front()});
        mon_idx++;
        if (mon_idx == 188) begin
          mon_idx = 0;
          pkt_cnt++;
        end
      end
    end
  end

  task automatic send_pkt(input logic [7:0] tag, input int len, input bit gaps, input bit push);
    logic [7:0] b;
    if (push && RST) exp_ch_q.push_back(tag[1:0]);
    for (int i = 0; i < len; i++) begin
      @(negedge CLK);
      if (!RST) begin
        D_VALID_IN = 1'b0;
        break;
      end
      b = (i == 0) ? tag : 8'($urandom);
      DATA_IN    = b;
      P_SYNC_IN  = (i == 0);
      D_VALID_IN = 1'b1;
      if (push) exp_b_q.push_back((i == 0) ? 8'h47 : b);
      last_cyc = cyc;
      if (gaps) begin
        @(negedge CLK);
        D_VALID_IN = 1'b0;
        DATA_IN    = 8'($urandom);
        P_SYNC_IN  = 1'($urandom);
      end
    end
  endtask

  task automatic idle_in();
    @(negedge CLK);
    D_VALID_IN = 1'b0;
    P_SYNC_IN  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge CLK);
      if (exp_ch_q.size() == 0 && mon_idx == 0) break;
    end
    if (i == 3000) chk({tag, "_drain"}, exp_ch_q.size(), 32'd0);
    repeat (20) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    seen_first = 0;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    RST = 1'b1; DATA_IN = 8'd0; D_VALID_IN = 1'b0; P_SYNC_IN = 1'b0; CH_ENABLE = 4'hF;
    #3 RST = 1'b0;
    #1;
    chk("rst_data", {24'd0, DATA_OUT}, 32'd0);
    chk("rst_vld", {28'd0, D_VALID_OUT}, 32'd0);
    chk("rst_psync", {31'd0, P_SYNC_OUT}, 32'd0);
    chk("rst_lock", {31'd0, SYNC_LOCKED}, 32'd0);
    chk("rst_err", {16'd0, ERR_COUNT}, 32'd0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;

    // Four back-to-back packets, one per channel.
    base = pkt_cnt;
    send_pkt(8'h44, 188, 0, 1);
    base = base;
    begin
      int lat_ref;
      lat_ref = last_cyc;
      send_pkt(8'h45, 188, 0, 1);
      send_pkt(8'h46, 188, 0, 1);
      send_pkt(8'h47, 188, 0, 1);
      idle_in();
      wait_drain("p1");
      chk("p1_latency", first_cyc - lat_ref, 32'd2);
    end
    chk("p1_pkts", pkt_cnt - base, 32'd4);
    chk("p1_lock", {31'd0, SYNC_LOCKED}, 32'd1);
    chk("p1_err", {16'd0, ERR_COUNT}, 32'd0);

    // Short ch1 packet followed by a good ch2 packet.
    do_reset();
    base = pkt_cnt;
    send_pkt(8'h45, 100, 0, 0);
    send_pkt(8'h46, 188, 0, 1);
    idle_in();
    wait_drain("p2");
    chk("p2_pkts", pkt_cnt - base, 32'd1);
    chk("p2_err", {16'd0, ERR_COUNT}, 32'd1);
    chk("p2_lock", {31'd0, SYNC_LOCKED}, 32'd0);

    // Bad tag, its body ignored, then a good packet.
    do_reset();
    base = pkt_cnt;
    send_pkt(8'h48, 188, 0, 0);
    send_pkt(8'h44, 188, 0, 1);
    idle_in();
    wait_drain("p3");
    chk("p3_pkts", pkt_cnt - base, 32'd1);
    chk("p3_err", {16'd0, ERR_COUNT}, 32'd1);

    // Channel 1 disabled while all channels stream.
    do_reset();
    CH_ENABLE = 4'b1101;
    base = pkt_cnt;
    for (int k = 0; k < 8; k++) send_pkt(8'h44 + 8'(k % 4), 188, 0, (k % 4) != 1);
    idle_in();
    wait_drain("p4");
    chk("p4_pkts", pkt_cnt - base, 32'd6);
    chk("p4_err", {16'd0, ERR_COUNT}, 32'd0);
    CH_ENABLE = 4'hF;

    // Half-rate input must still give gap-free output bursts.
    do_reset();
    base = pkt_cnt;
    send_pkt(8'h47, 188, 1, 1);
    send_pkt(8'h44, 188, 1, 1);
    send_pkt(8'h46, 188, 1, 1);
    idle_in();
    wait_drain("p5");
    chk("p5_pkts", pkt_cnt - base, 32'd3);
    chk("p5_err", {16'd0, ERR_COUNT}, 32'd0);
    chk("p5_lock", {31'd0, SYNC_LOCKED}, 32'd1);

    // Reset in the middle of an output packet.
    do_reset();
    fork
      begin
        send_pkt(8'h44, 188, 0, 1);
        send_pkt(8'h46, 188, 0, 1);
        D_VALID_IN = 1'b0;
      end
      begin
        int j;
        for (j = 0; j < 2000; j++) begin
          @(posedge CLK);
          if (mon_idx == 90) break;
        end
        chk("p6_reached_byte90", mon_idx, 32'd90);
        #1 RST = 1'b0;
        #1;
        chk("p6_data", {24'd0, DATA_OUT}, 32'd0);
        chk("p6_vld", {28'd0, D_VALID_OUT}, 32'd0);
        chk("p6_psync", {31'd0, P_SYNC_OUT}, 32'd0);
        chk("p6_lock", {31'd0, SYNC_LOCKED}, 32'd0);
        chk("p6_err", {16'd0, ERR_COUNT}, 32'd0);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
      end
    join
    idle_in();
    base = pkt_cnt;
    send_pkt(8'h47, 188, 0, 1);
    idle_in();
    wait_drain("p6");
    chk("p6_pkts", pkt_cnt - base, 32'd1);
    chk("p6_err_after", {16'd0, ERR_COUNT}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
